// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the EX-stage ALU / multiply-divide controller
package alu_ctrl_pkg;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010, ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100, ALU_SRL  = 4'b0101, ALU_SUB  = 4'b0110, ALU_SRA  = 4'b0111,
    ALU_BEQ  = 4'b1000, ALU_BNE  = 4'b1001, ALU_BLT  = 4'b1010, ALU_BGE  = 4'b1011,
    ALU_SLT  = 4'b1100, ALU_BLTU = 4'b1101, ALU_BGEU = 4'b1110, ALU_SLTU = 4'b1111
  } alu_op_e;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
endpackage

// File: rtl/md_divider.sv
// md_divider: iterative restoring unsigned divider, one quotient bit per cycle; quotient/remainder show the step result and are final while done is high
module md_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN + 1);
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [XLEN:0] trial, diff;
  // one restoring step: shift in the next dividend bit and subtract if it fits
  always_comb begin
    trial = {rem, quo[XLEN-1]};
    diff = trial - {1'b0, dvs};
    quotient = {quo[XLEN-2:0], ~diff[XLEN]};
    remainder = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    done = busy && cnt == CW'(1);
  end
  // iteration registers; start reloads, abort drops an in-flight division
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      busy <= 1'b0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(XLEN);
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (busy) begin
      quo <= quotient;
      rem <= remainder;
      cnt <= cnt - CW'(1);
      busy <= cnt != CW'(1);
    end
endmodule

// File: rtl/alu_md_controller.sv
// alu_md_controller: EX-stage ALU op decode plus iterative RV32M multiply/divide engine with pipeline stall
module alu_md_controller
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [3:0]      Operation,
  output logic            md_sel_o,
  output logic            stall_o,
  output logic            md_valid_o,
  output logic [XLEN-1:0] md_result_o
);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  alu_op_e rtype, btype, op_dec;
  md_state_e state, state_nx;
  md_op_e op_q;
  logic [2:0] cnt;
  logic [2*XLEN-1:0] prod, a_ext, b_ext;
  logic neg_q, neg_r, is_sgn, by_zero, special, start, mul_last, div_done;
  logic dv_busy, dv_done;
  logic [XLEN-1:0] a_mag, b_mag, quo, rem, spec_res, mul_res, div_res;
  // ALU operation decode; RV32M ops report ADD and raise md_sel_o
  always_comb begin
    case (Funct3)
      3'b000: rtype = (ALUOp == ALUOP_R && Funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: rtype = ALU_SLL;
      3'b010: rtype = ALU_SLT;
      3'b011: rtype = ALU_SLTU;
      3'b100: rtype = ALU_XOR;
      3'b101: rtype = Funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: rtype = ALU_OR;
      default: rtype = ALU_AND;
    endcase
    case (Funct3)
      3'b000: btype = ALU_BEQ;
      3'b001: btype = ALU_BNE;
      3'b100: btype = ALU_BLT;
      3'b101: btype = ALU_BGE;
      3'b110: btype = ALU_BLTU;
      3'b111: btype = ALU_BGEU;
      default: btype = ALU_ADD;
    endcase
    md_sel_o = ALUOp == ALUOP_R && Funct7 == FUNCT7_MULDIV;
    op_dec = ALUOp == ALUOP_BR ? btype :
             ((ALUOp == ALUOP_R && !md_sel_o) || ALUOp == ALUOP_I) ? rtype : ALU_ADD;
    Operation = op_dec;
  end
  // operand conditioning, special-case detection and result selection
  always_comb begin
    start = state == ST_IDLE && valid_i && md_sel_o && !flush_i;
    is_sgn = Funct3[2] & ~Funct3[0];
    by_zero = b_i == '0;
    special = Funct3[2] & (by_zero | (is_sgn & a_i == SMIN & b_i == '1));
    a_mag = (is_sgn & a_i[XLEN-1]) ? -a_i : a_i;
    b_mag = (is_sgn & b_i[XLEN-1]) ? -b_i : b_i;
    a_ext = {{XLEN{a_i[XLEN-1] & (Funct3[1:0] != 2'b11)}}, a_i};
    b_ext = {{XLEN{b_i[XLEN-1] & ~Funct3[1]}}, b_i};
    spec_res = Funct3[1] ? (by_zero ? a_i : '0) : (by_zero ? '1 : SMIN);
    mul_res = op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res = op_q[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    mul_last = state == ST_MUL && cnt == 3'(MUL_LAT - 1);
    div_done = state == ST_DIV && dv_done;
  end
  md_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start & Funct3[2] & ~special),
    .abort    (flush_i),
    .dividend (a_mag),
    .divisor  (b_mag),
    .busy     (dv_busy),
    .done     (dv_done),
    .quotient (quo),
    .remainder(rem)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_nx;
  // next state; flush always wins
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = !start ? ST_IDLE : !Funct3[2] ? ST_MUL : special ? ST_DONE : ST_DIV;
      ST_MUL: state_nx = mul_last ? ST_DONE : ST_MUL;
      ST_DIV: state_nx = div_done ? ST_DONE : dv_busy ? ST_DIV : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush_i) state_nx = ST_IDLE;
  end
  // stall and result-valid outputs
  always_comb begin
    stall_o = reset_n && !flush_i &&
              ((state == ST_IDLE && valid_i && md_sel_o) || state == ST_MUL || state == ST_DIV);
    md_valid_o = state == ST_DONE && !flush_i;
  end
  // captured op, product, sign fix-ups and the registered result
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op_q <= MD_MUL;
      cnt <= '0;
      prod <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      md_result_o <= '0;
    end else begin
      if (start) begin
        op_q <= md_op_e'(Funct3);
        cnt <= '0;
        prod <= a_ext * b_ext;
        neg_q <= is_sgn & (a_i[XLEN-1] ^ b_i[XLEN-1]);
        neg_r <= is_sgn & a_i[XLEN-1];
      end else if (state == ST_MUL) cnt <= cnt + 3'd1;
      if (start && special) md_result_o <= spec_res;
      else if (mul_last && !flush_i) md_result_o <= mul_res;
      else if (div_done && !flush_i) md_result_o <= div_res;
    end
endmodule

// File: tb/tb_alu_md_controller.sv
// tb_alu_md_controller: scoreboard bench with a plain-arithmetic reference model for decode and RV32M results
module tb_alu_md_controller;
  localparam int XLEN = 32;
  localparam int MUL_LAT = 2;
  localparam logic [31:0] SMIN = 32'h8000_0000;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic valid_i, flush_i;
  logic [31:0] a_i, b_i, md_result_o;
  logic [3:0] Operation;
  logic md_sel_o, stall_o, md_valid_o;
  typedef struct {logic [31:0] res; int due;} exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0, cyc = 0;
  logic [3:0] br_tab [8] = '{4'h8, 4'h9, 4'h2, 4'h2, 4'hA, 4'hB, 4'hD, 4'hE};
  logic [3:0] rt_tab [8] = '{4'h2, 4'h4, 4'hC, 4'hF, 4'h3, 4'h5, 4'h1, 4'h0};

  alu_md_controller #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .valid_i(valid_i), .flush_i(flush_i), .a_i(a_i), .b_i(b_i), .Operation(Operation),
    .md_sel_o(md_sel_o), .stall_o(stall_o), .md_valid_o(md_valid_o), .md_result_o(md_result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] p;
    case (f3)
      3'd0: p = 64'(sa * sb);
      3'd1: p = 64'(sa * sb) >> 32;
      3'd2: p = 64'(sa * longint'(ub)) >> 32;
      3'd3: p = (ua * ub) >> 32;
      3'd4: p = b == 0 ? '1 : 64'(sa / sb);
      3'd5: p = b == 0 ? '1 : ua / ub;
      3'd6: p = b == 0 ? ua : 64'(sa % sb);
      default: p = b == 0 ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT + 1;
    if (b == 0 || (!f3[0] && a == SMIN && b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [4:0] ref_dec(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3);
    if (aop == 2'b01) return {1'b0, br_tab[f3]};
    if (aop == 2'b10 && f7 == 7'b0000001) return {1'b1, 4'h2};
    if (aop[1]) begin
      if (f3 == 3'd0 && aop == 2'b10 && f7[5]) return {1'b0, 4'h6};
      if (f3 == 3'd5 && f7[5]) return {1'b0, 4'h7};
      return {1'b0, rt_tab[f3]};
    end
    return {1'b0, 4'h2};
  endfunction

  // monitor: every presented M result must match the oldest expectation, on time
  always @(negedge clk)
    if (md_valid_o) begin
      if (sbq.size() == 0) chk("unexpected md_valid", md_valid_o, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("md_result", md_result_o, e.res);
        chk("md_done_cycle", cyc, e.due);
      end
    end

  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int cut, input bit by_reset);
    int t0, due;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; a_i = a; b_i = b; valid_i = 1'b1;
    t0 = cyc;
    due = t0 + ref_lat(f3, a, b);
    if (cut < 0) sbq.push_back('{ref_md(f3, a, b), due});
    for (int k = 0; k <= XLEN + 2; k++) begin
      if (k == cut) begin
        if (by_reset) reset_n = 1'b0;
        else flush_i = 1'b1;
      end
      @(negedge clk);
      if (k == cut) begin
        chk("abort stall", stall_o, 0);
        chk("abort valid", md_valid_o, 0);
        if (by_reset) chk("reset result", md_result_o, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
        chk("post-abort stall", stall_o, 0);
        repeat (XLEN + 4) @(posedge clk);
        #1;
        return;
      end
      if (cyc == due) begin
        chk("done stall", stall_o, 0);
        chk("done valid", md_valid_o, 1);
        break;
      end
      chk("busy stall", stall_o, 1);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic dec_check(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3, input logic v);
    logic [4:0] e;
    ALUOp = aop; Funct7 = f7; Funct3 = f3; valid_i = v;
    e = ref_dec(aop, f7, f3);
    #1;
    chk("Operation", Operation, e[3:0]);
    chk("md_sel", md_sel_o, e[4]);
    if (!e[4]) chk("decode stall", stall_o, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
    flush_i = 1'b0; a_i = '0; b_i = '0; Funct3 = '0;
    ALUOp = 2'b10; Funct7 = 7'b0000001; valid_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset stall", stall_o, 0);
    chk("reset md_valid", md_valid_o, 0);
    chk("reset md_result", md_result_o, 0);
    @(posedge clk); #1;
    valid_i = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    dec_check(2'b10, 7'b0100000, 3'b000, 1'b1);
    dec_check(2'b01, 7'b0000000, 3'b110, 1'b1);
    dec_check(2'b11, 7'b0100000, 3'b000, 1'b1);
    dec_check(2'b11, 7'b0100000, 3'b101, 1'b1);
    dec_check(2'b00, 7'b0100000, 3'b101, 1'b1);
    valid_i = 1'b0;
    @(posedge clk); #1;
    run_md(3'd0, 32'hFFFF_FFFF, 32'd3, -1, 1'b0);
    run_md(3'd1, 32'hFFFF_FFFF, 32'd3, -1, 1'b0);
    run_md(3'd3, 32'hFFFF_FFFF, 32'd3, -1, 1'b0);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    run_md(3'd5, 32'd5, 32'd0, -1, 1'b0);
    run_md(3'd7, 32'd5, 32'd0, -1, 1'b0);
    run_md(3'd4, SMIN, 32'hFFFF_FFFF, -1, 1'b0);
    run_md(3'd6, SMIN, 32'hFFFF_FFFF, -1, 1'b0);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);
    run_md(3'd0, 32'd12345, 32'hFFFF_FFFE, -1, 1'b0);
    run_md(3'd4, 32'd100, 32'hFFFF_FFF9, -1, 1'b0);
    run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin ra = SMIN; rb = '1; end
        2: begin ra = ra % 300; rb = (rb % 17) - 8; end
        default: ;
      endcase
      run_md(3'($urandom_range(0, 7)), ra, rb, -1, 1'b0);
    end
    for (int i = 0; i < 30; i++)
      dec_check(2'($urandom_range(0, 3)), f7s[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
